// File: rtl/cfu_requant_pkg.sv
// Shared opcodes, FSM states and int32 limits for the requantization CFU stage.
package cfu_requant_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned FID_W  = 3;

    localparam logic [FID_W-1:0] OP_SET_MULT  = 3'd0;
    localparam logic [FID_W-1:0] OP_SET_SHIFT = 3'd1;
    localparam logic [FID_W-1:0] OP_SET_OUT   = 3'd2;
    localparam logic [FID_W-1:0] OP_REQUANT   = 3'd3;
    localparam logic [FID_W-1:0] OP_READ      = 3'd4;

    localparam logic [DATA_W-1:0] INT32_MIN = 32'h8000_0000;
    localparam logic [DATA_W-1:0] INT32_MAX = 32'h7FFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_SHIFT,
        ST_CLAMP,
        ST_RESP
    } state_e;

endpackage

// File: rtl/srdhm_mul.sv
// Saturating rounding doubling high multiply with a single output register,
// so the 32x32 product maps onto one DSP stage.
module srdhm_mul
    import cfu_requant_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] m_o
);

    logic signed [63:0] prod_c;
    logic signed [63:0] sum_c;
    logic signed [63:0] quo_c;
    logic               sat_c;
    logic [DATA_W-1:0]  m_d;
    logic [DATA_W-1:0]  m_q;

    // Negative sums get a bias of 2^31-1 so the arithmetic shift truncates toward zero.
    always_comb begin
        prod_c = 64'($signed(a_i)) * 64'($signed(b_i));
        sum_c  = prod_c + ((prod_c >= 0) ? 64'sd1073741824 : -64'sd1073741823);
        quo_c  = (sum_c < 0) ? ((sum_c + 64'sd2147483647) >>> 31) : (sum_c >>> 31);
        sat_c  = (a_i == INT32_MIN) && (b_i == INT32_MIN);
        m_d    = sat_c ? INT32_MAX : 32'(quo_c);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q <= '0;
        end else if (en_i) begin
            m_q <= m_d;
        end
    end

    assign m_o = m_q;

endmodule

// File: rtl/cfu_requant_stage.sv
// TFLite per-channel requantization CFU: bias add, SRDHM, rounding right shift,
// output offset and activation clamp behind a cmd/rsp handshake.
module cfu_requant_stage
    import cfu_requant_pkg::*;
#(
    parameter int unsigned OUT_BITS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [FID_W-1:0]  cmd_payload_function_id,
    input  logic [DATA_W-1:0] cmd_payload_inputs_0,
    input  logic [DATA_W-1:0] cmd_payload_inputs_1,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_payload_response_ok,
    output logic [DATA_W-1:0] rsp_payload_outputs_0
);

    localparam logic [15:0] ACT_MAX_RST = 16'((32'd1 << (OUT_BITS - 1)) - 32'd1);
    localparam logic [15:0] ACT_MIN_RST = ~ACT_MAX_RST;

    state_e            state_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] mult_q;
    logic [5:0]        shift_q;
    logic [DATA_W-1:0] offset_q;
    logic [15:0]       act_min_q;
    logic [15:0]       act_max_q;
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] r_q;

    logic              accept_c;
    logic [5:0]        neg_shift_c;
    logic [4:0]        ls_c;
    logic [4:0]        rs_c;
    logic [DATA_W-1:0] sum_c;
    logic [DATA_W-1:0] x_c;
    logic [DATA_W-1:0] mask_c;
    logic [DATA_W-1:0] rem_c;
    logic [DATA_W-1:0] thr_c;
    logic [DATA_W-1:0] r_c;
    logic signed [32:0] y_c;
    logic signed [32:0] min_c;
    logic signed [32:0] max_c;
    logic signed [32:0] lo_c;
    logic signed [32:0] cl_c;
    logic [DATA_W-1:0] res_c;
    logic [DATA_W-1:0] rd_c;
    logic [DATA_W-1:0] m_w;

    srdhm_mul u_srdhm (
        .clk   (clk),
        .reset (reset),
        .en_i  (state_q == ST_MUL),
        .a_i   (x_q),
        .b_i   (mult_q),
        .m_o   (m_w)
    );

    // Shift split, bias add, rounding divide by power of two and clamp datapath.
    always_comb begin
        accept_c    = cmd_valid && cmd_ready_q;
        neg_shift_c = 6'(~shift_q + 6'd1);
        ls_c        = shift_q[5] ? 5'd0 : shift_q[4:0];
        rs_c        = !shift_q[5] ? 5'd0 : (neg_shift_c[5] ? 5'd31 : neg_shift_c[4:0]);
        sum_c       = cmd_payload_inputs_0 + cmd_payload_inputs_1;
        x_c         = sum_c << ls_c;
        mask_c      = (32'd1 << rs_c) - 32'd1;
        rem_c       = m_w & mask_c;
        thr_c       = (mask_c >> 1) + {31'd0, m_w[31]};
        r_c         = 32'($signed(m_w) >>> rs_c) + {31'd0, (rem_c > thr_c)};
        y_c         = 33'($signed(r_q)) + 33'($signed(offset_q));
        min_c       = 33'($signed(act_min_q));
        max_c       = 33'($signed(act_max_q));
        lo_c        = (y_c < min_c) ? min_c : y_c;
        cl_c        = (lo_c > max_c) ? max_c : lo_c;
        res_c       = 32'(cl_c);
        case (cmd_payload_inputs_0[1:0])
            2'd0:    rd_c = mult_q;
            2'd1:    rd_c = 32'($signed(shift_q));
            2'd2:    rd_c = offset_q;
            default: rd_c = {act_max_q, act_min_q};
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            out_q       <= '0;
            mult_q      <= 32'h4000_0000;
            shift_q     <= '0;
            offset_q    <= '0;
            act_min_q   <= ACT_MIN_RST;
            act_max_q   <= ACT_MAX_RST;
            x_q         <= '0;
            r_q         <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        cmd_ready_q <= 1'b0;
                        if (cmd_payload_function_id == OP_REQUANT) begin
                            x_q     <= x_c;
                            state_q <= ST_MUL;
                        end else begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            case (cmd_payload_function_id)
                                OP_SET_MULT: begin
                                    mult_q <= cmd_payload_inputs_0;
                                    out_q  <= cmd_payload_inputs_0;
                                end
                                OP_SET_SHIFT: begin
                                    shift_q <= cmd_payload_inputs_0[5:0];
                                    out_q   <= 32'($signed(cmd_payload_inputs_0[5:0]));
                                end
                                OP_SET_OUT: begin
                                    offset_q  <= cmd_payload_inputs_0;
                                    act_min_q <= cmd_payload_inputs_1[15:0];
                                    act_max_q <= cmd_payload_inputs_1[31:16];
                                    out_q     <= '0;
                                end
                                OP_READ: out_q <= rd_c;
                                default: out_q <= '0;
                            endcase
                        end
                    end
                end
                ST_MUL:   state_q <= ST_SHIFT;
                ST_SHIFT: begin
                    r_q     <= r_c;
                    state_q <= ST_CLAMP;
                end
                ST_CLAMP: begin
                    out_q       <= res_c;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready               = cmd_ready_q;
    assign rsp_valid               = rsp_valid_q;
    assign rsp_payload_outputs_0   = out_q;
    assign rsp_payload_response_ok = 1'b1;

endmodule

// File: tb/tb_cfu_requant_stage.sv
// Bench for cfu_requant_stage: directed vector table, hand-written handshake/reset
// sequences, and randomized commands against an arithmetic reference model.
module tb_cfu_requant_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  fid;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_ok;
    logic [31:0] rsp_out;

    int total = 0;
    int bad   = 0;

    // Reference configuration, tracked at the level of the opcode semantics.
    int m_mult, m_shift, m_offset, m_min, m_max;

    typedef struct {
        logic [2:0]  fid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;
    vec_t vq[$];

    always #5 clk = ~clk;

    cfu_requant_stage #(.OUT_BITS(8)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (fid),
        .cmd_payload_inputs_0    (in0),
        .cmd_payload_inputs_1    (in1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_response_ok (rsp_ok),
        .rsp_payload_outputs_0   (rsp_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_mult = 32'h4000_0000; m_shift = 0; m_offset = 0; m_min = -128; m_max = 127;
    endfunction

    function automatic int model_requant(int acc, int bias);
        int s, x, m, r, ls, rs;
        longint p, nud, a, q, y;
        s  = acc + bias;
        ls = (m_shift > 0) ? m_shift : 0;
        rs = (m_shift < 0) ? -m_shift : 0;
        x  = s << ls;
        if (x == int'(32'h8000_0000) && m_mult == int'(32'h8000_0000)) begin
            m = int'(32'h7FFF_FFFF);
        end else begin
            p   = longint'(x) * longint'(m_mult);
            nud = (p >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824);
            m   = int'((p + nud) / 64'sd2147483648);
        end
        // Round half away from zero when dividing by 2^rs.
        if (rs == 0) begin
            r = m;
        end else begin
            a = (m < 0) ? -longint'(m) : longint'(m);
            q = (a + (longint'(1) << (rs - 1))) >> rs;
            r = (m < 0) ? int'(-q) : int'(q);
        end
        y = longint'(r) + longint'(m_offset);
        if (y < m_min) y = m_min;
        if (y > m_max) y = m_max;
        return int'(y);
    endfunction

    function automatic logic [31:0] model_cmd(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        logic [15:0] mn16, mx16;
        case (f)
            3'd0: begin m_mult = int'(a); return a; end
            3'd1: begin m_shift = int'($signed(a[5:0])); return 32'(m_shift); end
            3'd2: begin
                m_offset = int'(a);
                m_min = int'($signed(b[15:0]));
                m_max = int'($signed(b[31:16]));
                return 32'd0;
            end
            3'd3: return 32'(model_requant(int'(a), int'(b)));
            3'd4: begin
                mn16 = 16'(m_min);
                mx16 = 16'(m_max);
                case (a[1:0])
                    2'd0:    return 32'(m_mult);
                    2'd1:    return 32'(m_shift);
                    2'd2:    return 32'(m_offset);
                    default: return {mx16, mn16};
                endcase
            end
            default: return 32'd0;
        endcase
    endfunction

    // Issue one command, wait (bounded) for its response, then consume it.
    task automatic run_cmd(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int lat);
        int n;
        @(negedge clk);
        cmd_valid = 1'b1; fid = f; in0 = a; in1 = b;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: cmd_ready stuck low, required 1");
            cmd_valid = 1'b0; res = 'x; lat = -1;
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = rsp_out;
        if (!rsp_valid) begin
            total++; bad++;
            $display("FAIL rsp_timeout: rsp_valid stuck low, required 1");
            lat = -1;
            return;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    endtask

    initial begin
        logic [31:0] res, held, a, b, exp;
        logic [2:0]  f;
        int          lat, sh;
        logic        seen;

        reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; fid = '0; in0 = '0; in1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_outputs", rsp_out, 32'd0);
        chk("rsp_ok", 32'(rsp_ok), 32'd1);
        reset = 1'b1;

        vq.push_back('{3'd3, 32'd100,        32'd0,        32'd50,         "ident100"});
        vq.push_back('{3'd3, 32'd101,        32'd0,        32'd51,         "round101"});
        vq.push_back('{3'd1, 32'h0000_003F,  32'd0,        32'hFFFF_FFFF,  "set_shift_m1"});
        vq.push_back('{3'd3, 32'd101,        32'd0,        32'd26,         "rshift101"});
        vq.push_back('{3'd1, 32'd0,          32'd0,        32'd0,          "set_shift_0"});
        vq.push_back('{3'd3, 32'hFFFF_FFFD,  32'd0,        32'hFFFF_FFFF,  "neg3"});
        vq.push_back('{3'd2, 32'hFFFF_FF80,  32'h007F_FF80, 32'd0,         "set_out"});
        vq.push_back('{3'd3, 32'd100,        32'd0,        32'hFFFF_FFB2,  "offset_m78"});
        vq.push_back('{3'd3, 32'd1000,       32'd24,       32'd127,        "clamp_hi"});
        vq.push_back('{3'd3, 32'hFFFF_FC18,  32'd0,        32'hFFFF_FF80,  "clamp_lo"});
        vq.push_back('{3'd4, 32'd0,          32'd0,        32'h4000_0000,  "rd_mult"});
        vq.push_back('{3'd4, 32'd3,          32'd0,        32'h007F_FF80,  "rd_minmax"});
        vq.push_back('{3'd4, 32'd2,          32'd0,        32'hFFFF_FF80,  "rd_offset"});
        vq.push_back('{3'd0, 32'h8000_0000,  32'd0,        32'h8000_0000,  "set_mult_min"});
        vq.push_back('{3'd2, 32'd0,          32'h7FFF_8000, 32'd0,         "set_out16"});
        vq.push_back('{3'd3, 32'h8000_0000,  32'd0,        32'd32767,      "saturate"});
        vq.push_back('{3'd0, 32'h4000_0000,  32'd0,        32'h4000_0000,  "set_mult_half"});
        vq.push_back('{3'd1, 32'd31,         32'd0,        32'd31,         "set_shift_31"});
        vq.push_back('{3'd3, 32'd1,          32'd0,        32'hFFFF_8000,  "lshift31_wrap"});
        vq.push_back('{3'd4, 32'd1,          32'd0,        32'd31,         "rd_shift"});
        vq.push_back('{3'd5, 32'd7,          32'd9,        32'd0,          "op5_nop"});
        vq.push_back('{3'd1, 32'd0,          32'd0,        32'd0,          "shift_back_0"});

        foreach (vq[i]) begin
            run_cmd(vq[i].fid, vq[i].a, vq[i].b, res, lat);
            chk(vq[i].name, res, vq[i].exp);
            chk({vq[i].name, "_lat"}, 32'(lat), (vq[i].fid == 3'd3) ? 32'd4 : 32'd1);
        end

        // Back-pressure: response held and no new command taken until handshake.
        @(negedge clk);
        cmd_valid = 1'b1; fid = 3'd3; in0 = 32'd100; in1 = 32'd0;
        @(negedge clk);
        cmd_valid = 1'b1; fid = 3'd3; in0 = 32'd200; in1 = 32'd2;
        wait_rsp("bp_first");
        held = rsp_out;
        chk("bp_first_val", held, 32'd50);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_out", rsp_out, 32'd50);
            chk("bp_hold_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_ready_after_hs", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_second_taken", 32'(cmd_ready), 32'd0);
        wait_rsp("bp_second");
        chk("bp_second_val", rsp_out, 32'd101);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // rsp_ready while idle must not produce a response.
        rsp_ready = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        rsp_ready = 1'b0;
        chk("idle_rsp_ready", 32'(seen), 32'd0);

        // Reset while a response is pending drops rsp_valid without a clock edge.
        @(negedge clk);
        cmd_valid = 1'b1; fid = 3'd0; in0 = 32'h1234_5678; in1 = 32'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp("resp_pending");
        #2 reset = 1'b0;
        #1 chk("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Reset in the MUL state after changing every config register.
        run_cmd(3'd0, 32'h1111_1111, 32'd0, res, lat);
        run_cmd(3'd1, 32'd5, 32'd0, res, lat);
        run_cmd(3'd2, 32'd9, 32'h0010_FFF0, res, lat);
        @(negedge clk);
        cmd_valid = 1'b1; fid = 3'd3; in0 = 32'd100; in1 = 32'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        reset = 1'b0;
        #1 chk("mul_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk("mul_rst_no_stale", 32'(seen), 32'd0);
        chk("mul_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        run_cmd(3'd4, 32'd0, 32'd0, res, lat);
        chk("post_rst_mult", res, 32'h4000_0000);
        run_cmd(3'd4, 32'd1, 32'd0, res, lat);
        chk("post_rst_shift", res, 32'd0);
        run_cmd(3'd4, 32'd2, 32'd0, res, lat);
        chk("post_rst_offset", res, 32'd0);
        run_cmd(3'd4, 32'd3, 32'd0, res, lat);
        chk("post_rst_minmax", res, 32'h007F_FF80);

        // Randomized commands against the reference model, starting from reset config.
        model_reset();
        for (int i = 0; i < 300; i++) begin
            f = ($urandom_range(0, 9) < 5) ? 3'd3 : 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (f == 3'd1) begin
                sh = int'($urandom_range(0, 62)) - 31;
                a[5:0] = 6'(sh);
            end
            if (f == 3'd0 && $urandom_range(0, 3) == 0) a = 32'h8000_0000;
            if (f == 3'd3 && $urandom_range(0, 1) == 1) begin
                a = 32'(int'($urandom_range(0, 4000)) - 2000);
                b = 32'(int'($urandom_range(0, 200)) - 100);
            end
            exp = model_cmd(f, a, b);
            run_cmd(f, a, b, res, lat);
            chk($sformatf("rand%0d_op%0d", i, f), res, exp);
            chk($sformatf("rand%0d_lat", i), 32'(lat), (f == 3'd3) ? 32'd4 : 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
